// File: rtl/obi_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// obi_mem_responder
//
// OBI responder backing a word-addressed register-file memory. Requests are
// granted combinationally while fewer than MaxOutstanding transactions are in
// flight. Each accepted transaction produces exactly one response,
// RespLatency cycles after its accept edge, strictly in acceptance order.
//
// Writes merge wdata into the addressed word under the byte enables.
// Reads capture the addressed word on the accept edge.
// Accesses outside [BaseAddr, BaseAddr + 4*NumWords) still get a normally
// timed response: a write is dropped, and a read returns ErrData.
// Write responses always carry rdata = 0.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset; clears the memory, the
//                 outstanding counter and every in-flight response
//   slave_req_i   packed request, MSB first:
//                   [69]    req
//                   [68]    we
//                   [67:64] be
//                   [63:32] addr
//                   [31:0]  wdata
//   slave_resp_o  packed response, MSB first:
//                   [33]    gnt     (combinational)
//                   [32]    rvalid  (registered)
//                   [31:0]  rdata   (registered, holds when rvalid = 0)
//
// The bit layout is that of the packed obi_req_t / obi_resp_t structs
// (first field in the MSBs), so struct-typed signals connect directly.
// -----------------------------------------------------------------------------
module obi_mem_responder #(
   parameter int          NumWords       = 256,
   parameter int          RespLatency    = 1,
   parameter int          MaxOutstanding = 2,
   parameter logic [31:0] BaseAddr       = 32'h0,
   parameter logic [31:0] ErrData        = 32'hBADCAB1E
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [69:0] slave_req_i,
   output logic [33:0] slave_resp_o
);

   localparam int IdxW = $clog2(NumWords);
   localparam int CntW = $clog2(MaxOutstanding + 1);

   // ---------------------------------------------------------------
   // Request unpacking and address decode
   // ---------------------------------------------------------------
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;

   assign {req, we, be, addr, wdata} = slave_req_i;

   logic [31:0]     offset;
   logic [IdxW-1:0] idx;
   logic            in_range;
   logic            unused_lsbs;

   assign offset = addr - BaseAddr;
   assign idx    = offset[IdxW+1:2];
   // Once addr >= BaseAddr the subtraction cannot wrap, so the upper offset
   // bits being zero is the same as addr < BaseAddr + 4*NumWords.
   assign in_range    = (addr >= BaseAddr) && (offset[31:IdxW+2] == '0);
   // Byte offset within the word is ignored.
   assign unused_lsbs = ^offset[1:0];

   // ---------------------------------------------------------------
   // Handshake and outstanding counter
   // ---------------------------------------------------------------
   logic [CntW-1:0] cnt;
   logic            gnt;
   logic            accept;
   logic            rvalid;
   logic            wr_en;

   // Gated by rst_ni so gnt reads 0 while the block is held in reset.
   // No dependence on rvalid: a slot freed by a response only becomes
   // available in the following cycle.
   assign gnt    = rst_ni & req & (cnt < CntW'(MaxOutstanding));
   assign accept = req & gnt;
   assign wr_en  = accept & we & in_range;

   // Accept and response in the same cycle cancel out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CntW'(accept) - CntW'(rvalid);
      end
   end

   // ---------------------------------------------------------------
   // Memory: register file, cleared by reset
   // ---------------------------------------------------------------
   logic [31:0] mem [NumWords];
   logic [31:0] rd_word;

   // Read before write on the accept edge; only one request is accepted
   // per cycle, so no bypass is ever needed.
   assign rd_word = mem[idx];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < NumWords; w++) begin
            mem[w] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Response pipeline
   // ---------------------------------------------------------------
   logic [31:0]            resp_data;
   logic [RespLatency-1:0] stage_valid;
   logic [31:0]            stage_data [RespLatency];

   always_comb begin
      resp_data = '0;
      if (!we) begin
         resp_data = in_range ? rd_word : ErrData;
      end
   end

   // Stage 0 is loaded on the accept edge; the last stage drives the
   // outputs. Data moves only alongside a valid bit, so the output stage
   // keeps the last delivered rdata through idle cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid <= '0;
         for (int s = 0; s < RespLatency; s++) begin
            stage_data[s] <= '0;
         end
      end else begin
         stage_valid[0] <= accept;
         if (accept) begin
            stage_data[0] <= resp_data;
         end
         for (int s = 1; s < RespLatency; s++) begin
            stage_valid[s] <= stage_valid[s-1];
            if (stage_valid[s-1]) begin
               stage_data[s] <= stage_data[s-1];
            end
         end
      end
   end

   assign rvalid       = stage_valid[RespLatency-1];
   assign slave_resp_o = {gnt, rvalid, stage_data[RespLatency-1]};

   // ---------------------------------------------------------------
   // Counter sanity
   // ---------------------------------------------------------------
   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt <= CntW'(MaxOutstanding));

   // A response with nothing outstanding would make the counter underflow.
   a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rvalid |-> (cnt != '0));

endmodule
